cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

The common data bus arbiter shares the single result broadcast bus between the six completing units: ADD1, ADD2, ADD3, MULT1, MULT2 and the load/store unit. Each cycle it grants at most one pending requester using round-robin priority. It registers the winner's tag and result onto the CDB, where the reservation stations, rename table and reorder buffer consume them. Losing units hold their result until granted, and the bus stalls when the reorder buffer deasserts `cdb_ready`.

## Interface
- `DATA_W`, 32, result width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `add1_req`, `add2_req`, `add3_req`, `mul1_req`, `mul2_req` in 1 each: unit has a completed result.
- `add1_data` … `mul2_data` in DATA_W each: result, stable while the matching req is high.
- `ls_req` in 1: load/store unit has a completed result.
- `ls_data` in DATA_W: load/store result.
- `ls_idx` in 3: load/store buffer entry.
- `add1_gnt` … `mul2_gnt`, `ls_gnt` out 1 each: combinational grant, one-hot or zero.
- `cdb_ready` in 1: the reorder buffer accepts the current broadcast this cycle.
- `cdb_valid` out 1: broadcast valid.
- `cdb_tag` out 4: producer tag.
- `cdb_data` out DATA_W: broadcast result.

## Operation
- **Tag encoding** (matches reservation-station index):
  - ADD1=1, ADD2=2, ADD3=3, MULT1=4, MULT2=5.
  - LS = {1'b1, ls_idx}, which gives 8..15.
  - 0 = no producer.
- **Request vector order:** ADD1, ADD2, ADD3, MULT1, MULT2, LS, mapped to indices 0..5.
- **Slot free:** `slot_free = !cdb_valid | cdb_ready`.
- **Grant:**
  - If `slot_free` and any req is high, grant the first requesting index at or after `rr_ptr`, searching cyclically modulo 6.
  - Otherwise all gnt signals are 0.
- **Pointer update:** on a grant to index i, `rr_ptr <= (i==5) ? 0 : i+1`. With no grant, `rr_ptr` holds.
- **Output register:**
  - On a grant: `cdb_valid <= 1`, and `cdb_tag`/`cdb_data` are loaded from the winner.
  - Else if `cdb_ready`: `cdb_valid <= 0`, and tag/data hold their old values (don't-care).
  - Else: all outputs hold.
- **Requester rule:**
  - A unit keeps req and data stable until it samples gnt=1 at a rising edge.
  - It drops req in the following cycle unless it has a new result.
  - Req with gnt=0 is never lost.
- **Back-to-back:** while `cdb_ready` stays high, one result per cycle is broadcast.
- **Simultaneous events:** with all six requesting and `cdb_ready` constantly 1, each unit is granted exactly once in 6 consecutive cycles. Maximum wait for any requester is 5 grant cycles.
- **Stall:** with `cdb_valid=1` and `cdb_ready=0`, there are no grants, `cdb_*` is frozen, and `rr_ptr` is frozen.
- **`ls_idx` handling:** sampled only on the edge where LS is granted.
- **Reset:**
  - `cdb_valid=0`, `cdb_tag=0`, `cdb_data=0`, `rr_ptr=0` (ADD1 first).
  - Grants are 0 while `rst_n=0`.
  - Reset asserted mid-stall drops the pending broadcast; requesters re-present after reset.

## Timing
- The grant decision is combinational from req, `rr_ptr`, `cdb_valid` and `cdb_ready` in cycle t.
- The broadcast appears with `cdb_valid=1` in cycle t+1, so request-to-broadcast latency is 1 cycle when uncontended.
- A broadcast is consumed in the first cycle where `cdb_valid & cdb_ready`. A new grant may occur in that same cycle, so there are no bubbles.
- There is no combinational path from `cdb_data` inputs to outputs; `cdb_*` are registered.
- `cdb_ready` to gnt is a combinational path and is kept to one gate level after the priority encoder.

## Test plan
- **Reset:** hold `rst_n=0` with all reqs=1 → all gnt=0, `cdb_valid=0`, `cdb_tag=0`. Release → the first grant goes to ADD1, and `cdb_tag=1` on the next cycle.
- **Single request:** `mul2_req=1`, `mul2_data=32'hDEADBEEF`, `cdb_ready=1` → `mul2_gnt=1` in the same cycle; next cycle `cdb_valid=1`, `cdb_tag=5`, `cdb_data=DEADBEEF`; `rr_ptr` becomes 5 (LS).
- **Full contention:** all six reqs held, each dropped after its grant, `ls_idx=3`, `cdb_ready=1` → tags broadcast in order 1, 2, 3, 4, 5, 11 on consecutive cycles, with no duplicates and no gaps.
- **Round-robin fairness:** ADD1 and MULT1 requesting continuously, re-asserting after each grant → grants alternate ADD1, MULT1, ADD1, MULT1 over 4 cycles.
- **Stall:** broadcast tag 2 pending, `cdb_ready=0` for 3 cycles while ADD3 requests → `add3_gnt=0` and `cdb_tag`/`cdb_data` unchanged for 3 cycles. Raise `cdb_ready` → `add3_gnt=1` that cycle, and `cdb_tag=3` next cycle.
- **Reset mid-stall:** `cdb_valid=1`, `cdb_ready=0`, assert `rst_n=0` asynchronously → `cdb_valid` drops immediately with no clock edge, and `rr_ptr` returns to 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the single common data bus between the six completing units
// (ADD1, ADD2, ADD3, MULT1, MULT2, load/store). Each cycle at most one pending
// requester is granted with round-robin priority; the winner's tag and result
// are registered onto the CDB for the reservation stations, rename table and
// reorder buffer. The bus stalls while a broadcast is valid and the reorder
// buffer holds cdb_ready low.
//
// Parameters
//   DATA_W      result width
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   *_req       unit has a completed result (held until granted)
//   *_data      unit result, stable while its req is high
//   ls_idx      load/store buffer entry, forms the LS tag {1'b1, ls_idx}
//   *_gnt       combinational grant, one-hot or zero
//   cdb_ready   reorder buffer accepts the current broadcast this cycle
//   cdb_valid   broadcast valid
//   cdb_tag     producer tag (1..5 for ADD1..MULT2, 8..15 for LS, 0 = none)
//   cdb_data    broadcast result
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              add1_req,
    input  logic              add2_req,
    input  logic              add3_req,
    input  logic              mul1_req,
    input  logic              mul2_req,
    input  logic              ls_req,

    input  logic [DATA_W-1:0] add1_data,
    input  logic [DATA_W-1:0] add2_data,
    input  logic [DATA_W-1:0] add3_data,
    input  logic [DATA_W-1:0] mul1_data,
    input  logic [DATA_W-1:0] mul2_data,
    input  logic [DATA_W-1:0] ls_data,
    input  logic [2:0]        ls_idx,

    output logic              add1_gnt,
    output logic              add2_gnt,
    output logic              add3_gnt,
    output logic              mul1_gnt,
    output logic              mul2_gnt,
    output logic              ls_gnt,

    input  logic              cdb_ready,
    output logic              cdb_valid,
    output logic [3:0]        cdb_tag,
    output logic [DATA_W-1:0] cdb_data
);

    localparam int N_REQ = 6;

    // Isolate the lowest set bit (two's complement trick).
    function automatic logic [N_REQ-1:0] lowest_one(input logic [N_REQ-1:0] v);
        return v & (~v + N_REQ'(1));
    endfunction

    // One-hot to request index; zero input maps to index 0 (unused then).
    function automatic logic [2:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Producer tag for a request index; LS carries its buffer entry.
    function automatic logic [3:0] idx_to_tag(input logic [2:0] idx, input logic [2:0] lsi);
        return (idx == 3'd5) ? {1'b1, lsi} : 4'(idx + 3'd1);
    endfunction

    // ---- stage p0: request collection, round-robin pick, grant -------------
    logic [N_REQ-1:0]  req_p0;
    logic [N_REQ-1:0]  ptr_mask_p0;
    logic [N_REQ-1:0]  req_hi_p0;
    logic [N_REQ-1:0]  pick_p0;
    logic [N_REQ-1:0]  gnt_p0;
    logic              slot_free_p0;
    logic              vld_p0;
    logic [2:0]        win_idx_p0;
    logic [2:0]        next_ptr_p0;
    logic [3:0]        win_tag_p0;
    logic [DATA_W-1:0] win_data_p0;
    logic [2:0]        rr_ptr;

    assign req_p0 = {ls_req, mul2_req, mul1_req, add3_req, add2_req, add1_req};

    // Requests at or above rr_ptr take precedence; if none, wrap to the
    // lowest requester overall. This is the cyclic search from rr_ptr.
    assign ptr_mask_p0 = N_REQ'(6'h3F << rr_ptr);
    assign req_hi_p0   = req_p0 & ptr_mask_p0;
    assign pick_p0     = (|req_hi_p0) ? lowest_one(req_hi_p0) : lowest_one(req_p0);

    // The priority encoder does not depend on cdb_ready, so ready only
    // passes through this final AND on its way to the grants. rst_n is
    // folded in so nothing is granted while reset is held.
    assign slot_free_p0 = rst_n & (~cdb_valid | cdb_ready);
    assign gnt_p0       = pick_p0 & {N_REQ{slot_free_p0}};
    assign vld_p0       = |gnt_p0;

    assign add1_gnt = gnt_p0[0];
    assign add2_gnt = gnt_p0[1];
    assign add3_gnt = gnt_p0[2];
    assign mul1_gnt = gnt_p0[3];
    assign mul2_gnt = gnt_p0[4];
    assign ls_gnt   = gnt_p0[5];

    assign win_idx_p0  = onehot_to_idx(pick_p0);
    assign next_ptr_p0 = (win_idx_p0 == 3'd5) ? 3'd0 : win_idx_p0 + 3'd1;
    assign win_tag_p0  = idx_to_tag(win_idx_p0, ls_idx);

    always_comb begin
        win_data_p0 = '0;
        unique case (win_idx_p0)
            3'd0:    win_data_p0 = add1_data;
            3'd1:    win_data_p0 = add2_data;
            3'd2:    win_data_p0 = add3_data;
            3'd3:    win_data_p0 = mul1_data;
            3'd4:    win_data_p0 = mul2_data;
            default: win_data_p0 = ls_data;
        endcase
    end

    // ---- stage p1: CDB output register and round-robin pointer -------------
    // A grant can only happen when the slot is free, so loading here also
    // retires the previous broadcast in the same cycle (no bubbles).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= 4'd0;
            cdb_data  <= '0;
            rr_ptr    <= 3'd0;
        end else if (vld_p0) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= win_tag_p0;
            cdb_data  <= win_data_p0;
            rr_ptr    <= next_ptr_p0;
        end else if (cdb_ready) begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [5:0]  req_v;
    logic [31:0] data_v [6];
    logic [2:0]  ls_idx;
    logic        cdb_ready;

    logic        add1_gnt, add2_gnt, add3_gnt, mul1_gnt, mul2_gnt, ls_gnt;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [5:0]  gnt_v;

    assign gnt_v = {ls_gnt, mul2_gnt, mul1_gnt, add3_gnt, add2_gnt, add1_gnt};

    cdb_arbiter #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .add1_req  (req_v[0]),
        .add2_req  (req_v[1]),
        .add3_req  (req_v[2]),
        .mul1_req  (req_v[3]),
        .mul2_req  (req_v[4]),
        .ls_req    (req_v[5]),
        .add1_data (data_v[0]),
        .add2_data (data_v[1]),
        .add3_data (data_v[2]),
        .mul1_data (data_v[3]),
        .mul2_data (data_v[4]),
        .ls_data   (data_v[5]),
        .ls_idx    (ls_idx),
        .add1_gnt  (add1_gnt),
        .add2_gnt  (add2_gnt),
        .add3_gnt  (add3_gnt),
        .mul1_gnt  (mul1_gnt),
        .mul2_gnt  (mul2_gnt),
        .ls_gnt    (ls_gnt),
        .cdb_ready (cdb_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: state of the broadcast slot and the next-priority unit.
    logic        m_valid;
    logic [3:0]  m_tag;
    logic [31:0] m_data;
    int          m_ptr;
    logic [5:0]  last_gnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_tag   = 4'd0;
        m_data  = 32'd0;
        m_ptr   = 0;
    endtask

    // Winner by the arbitration rule: first requester cyclically from m_ptr,
    // only when the slot is free and reset is released.
    function automatic int model_win();
        if (!rst_n) return -1;
        if (m_valid && !cdb_ready) return -1;
        for (int k = 0; k < 6; k++) begin
            int i;
            i = (m_ptr + k) % 6;
            if (req_v[i]) return i;
        end
        return -1;
    endfunction

    // Called just after a falling edge with inputs already applied.
    // Checks grant and CDB state, advances one clock, updates the model,
    // and drops the granted unit's request.
    task automatic cycle();
        int w;
        logic [5:0] want_g;
        #2;
        w = model_win();
        want_g = (w < 0) ? 6'd0 : (6'd1 << w);
        last_gnt = gnt_v;
        check("gnt", {26'd0, gnt_v}, {26'd0, want_g});
        check("cdb_valid", {31'd0, cdb_valid}, {31'd0, m_valid});
        check("cdb_tag", {28'd0, cdb_tag}, {28'd0, m_tag});
        check("cdb_data", cdb_data, m_data);
        @(posedge clk);
        if (w >= 0) begin
            m_valid = 1'b1;
            m_tag   = (w == 5) ? 4'(8 + int'(ls_idx)) : 4'(w + 1);
            m_data  = data_v[w];
            m_ptr   = (w + 1) % 6;
        end else if (cdb_ready) begin
            m_valid = 1'b0;
        end
        #1;
        if (w >= 0) req_v[w] = 1'b0;
        @(negedge clk);
    endtask

    int full_tags [6] = '{1, 2, 3, 4, 5, 11};
    logic [31:0] held_data;

    initial begin
        rst_n     = 1'b0;
        cdb_ready = 1'b1;
        ls_idx    = 3'd3;
        req_v     = 6'h3F;
        for (int i = 0; i < 6; i++) data_v[i] = 32'h1000_0000 * (i + 1) + 32'h55;
        last_gnt  = 6'd0;
        model_reset();

        // Reset held with every unit requesting.
        repeat (2) @(negedge clk);
        #2;
        check("rst_gnt", {26'd0, gnt_v}, 32'd0);
        check("rst_valid", {31'd0, cdb_valid}, 32'd0);
        check("rst_tag", {28'd0, cdb_tag}, 32'd0);
        check("rst_data", cdb_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full contention straight out of reset: ADD1 first, LS last.
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("full_gnt", {26'd0, last_gnt}, 32'd1 << k);
            check("full_tag", {28'd0, cdb_tag}, full_tags[k]);
        end
        cycle();
        check("idle_valid", {31'd0, cdb_valid}, 32'd0);

        // Single request from MULT2.
        req_v[4]  = 1'b1;
        data_v[4] = 32'hDEAD_BEEF;
        cycle();
        check("single_gnt", {26'd0, last_gnt}, 32'h10);
        check("single_tag", {28'd0, cdb_tag}, 32'd5);
        check("single_data", cdb_data, 32'hDEAD_BEEF);
        // Pointer now at LS: LS beats ADD1.
        req_v[0] = 1'b1;
        req_v[5] = 1'b1;
        ls_idx   = 3'd6;
        cycle();
        check("ptr_ls_gnt", {26'd0, last_gnt}, 32'h20);
        check("ptr_ls_tag", {28'd0, cdb_tag}, 32'd14);

        // Fairness: ADD1 and MULT1 re-asserting after every grant.
        req_v[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("rr_gnt", {26'd0, last_gnt}, (k % 2 == 0) ? 32'h01 : 32'h08);
            req_v[0] = 1'b1;
            req_v[3] = 1'b1;
            data_v[0] = $urandom;
            data_v[3] = $urandom;
        end
        req_v[0] = 1'b0;
        req_v[3] = 1'b0;
        cycle();

        // Stall with tag 2 pending while ADD3 waits.
        req_v[1] = 1'b1;
        cycle();
        check("stall_pre_tag", {28'd0, cdb_tag}, 32'd2);
        held_data = data_v[1];
        cdb_ready = 1'b0;
        req_v[2]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_gnt", {26'd0, last_gnt}, 32'd0);
            check("stall_tag", {28'd0, cdb_tag}, 32'd2);
            check("stall_data", cdb_data, held_data);
        end
        cdb_ready = 1'b1;
        cycle();
        check("unstall_gnt", {26'd0, last_gnt}, 32'h04);
        check("unstall_tag", {28'd0, cdb_tag}, 32'd3);

        // Reset mid-stall: MULT1 broadcast pending, ADD1 and MULT2 waiting.
        req_v[3] = 1'b1;
        cycle();
        cdb_ready = 1'b0;
        req_v[0]  = 1'b1;
        req_v[4]  = 1'b1;
        cycle();
        check("mid_valid_pre", {31'd0, cdb_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, cdb_valid}, 32'd0);
        check("async_tag", {28'd0, cdb_tag}, 32'd0);
        check("async_gnt", {26'd0, gnt_v}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        cdb_ready = 1'b1;
        cycle();
        check("post_rst_gnt", {26'd0, last_gnt}, 32'h01);
        cycle();
        check("post_rst_gnt2", {26'd0, last_gnt}, 32'h10);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 6; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    req_v[i]  = 1'b1;
                    data_v[i] = $urandom;
                    if (i == 5) ls_idx = 3'($urandom_range(0, 7));
                end
            end
            cdb_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
